// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide scheduler: op codes, FSM states
// and the divide-by-zero LO value.
package md_pkg;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_md_op(input logic [2:0] code);
    return (code == OP_MULT) || (code == OP_MULTU) ||
           (code == OP_DIV)  || (code == OP_DIVU);
  endfunction

  function automatic logic is_mul_op(input logic [2:0] code);
    return (code == OP_MULT) || (code == OP_MULTU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] code);
    return (code == OP_MULT) || (code == OP_DIV);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// Bundle between EX, the scheduler and the external mul/div units.
// Handshake: *_start is held high from the first busy cycle through the cycle
// the unit's *_ready is sampled high; the result is taken on that same edge.
interface md_sched_if;
  import md_pkg::*;

  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_src1;
  logic [31:0] op_src2;
  logic        stall_down;

  logic        mul_start;
  logic        mul_sign;
  logic [31:0] mul_op1;
  logic [31:0] mul_op2;
  logic        mul_ready;
  logic [63:0] mul_result;

  logic        div_start;
  logic        div_sign;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_ready;
  logic [63:0] div_result;

  logic        stallreq;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy;
  logic        err_timeout;
  md_state_e   state_dbg;

  modport slave (
    input  op_valid, op_code, op_src1, op_src2, stall_down,
    input  mul_ready, mul_result, div_ready, div_result,
    output mul_start, mul_sign, mul_op1, mul_op2,
    output div_start, div_sign, div_op1, div_op2,
    output stallreq, hilo_we, hi_o, lo_o, busy, err_timeout, state_dbg
  );

  modport master (
    output op_valid, op_code, op_src1, op_src2, stall_down,
    output mul_ready, mul_result, div_ready, div_result,
    input  mul_start, mul_sign, mul_op1, mul_op2,
    input  div_start, div_sign, div_op1, div_op2,
    input  stallreq, hilo_we, hi_o, lo_o, busy, err_timeout, state_dbg
  );

endinterface

// File: rtl/md_sched.sv
// Multiply/divide scheduler: latches one request, drives the selected unit,
// stalls EX until the result (or a timeout / divide-by-zero) is available.
module md_sched
  import md_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  md_sched_if.slave   bus
);

  md_state_e         state_q, state_d;
  logic [31:0]       src1_q, src1_d;
  logic [31:0]       src2_q, src2_d;
  logic              sign_q, sign_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              err_q, err_d;

  logic              req;
  logic              unit_ready;
  logic [63:0]       unit_result;

  assign req         = bus.op_valid && is_md_op(bus.op_code);
  assign unit_ready  = (state_q == ST_MUL) ? bus.mul_ready  : bus.div_ready;
  assign unit_result = (state_q == ST_MUL) ? bus.mul_result : bus.div_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src1_q  <= '0;
      src2_q  <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          src1_d = bus.op_src1;
          src2_d = bus.op_src2;
          sign_d = is_signed_op(bus.op_code);
          cnt_d  = '0;
          if (is_mul_op(bus.op_code)) begin
            state_d = ST_MUL;
          end else if (bus.op_src2 == 32'd0) begin
            // Divide-by-zero never reaches the divider.
            state_d = ST_DONE;
            hi_d    = bus.op_src1;
            lo_d    = DIV0_LO;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (unit_ready) begin
          state_d = ST_DONE;
          hi_d    = unit_result[63:32];
          lo_d    = unit_result[31:0];
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_DONE;
          hi_d    = '0;
          lo_d    = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (!bus.stall_down) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request outputs decode registered state, so they drop with the state.
  assign bus.mul_start = (state_q == ST_MUL);
  assign bus.mul_sign  = (state_q == ST_MUL) ? sign_q : 1'b0;
  assign bus.mul_op1   = (state_q == ST_MUL) ? src1_q : '0;
  assign bus.mul_op2   = (state_q == ST_MUL) ? src2_q : '0;
  assign bus.div_start = (state_q == ST_DIV);
  assign bus.div_sign  = (state_q == ST_DIV) ? sign_q : 1'b0;
  assign bus.div_op1   = (state_q == ST_DIV) ? src1_q : '0;
  assign bus.div_op2   = (state_q == ST_DIV) ? src2_q : '0;

  assign bus.stallreq    = req && (state_q != ST_DONE);
  assign bus.hilo_we     = (state_q == ST_DONE);
  assign bus.hi_o        = hi_q;
  assign bus.lo_o        = lo_q;
  assign bus.busy        = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.err_timeout = err_q;
  assign bus.state_dbg   = state_q;

endmodule
